// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/flush controller: FSM state encodings and the pipeline NOP.
// Counter outputs are optional and appear only when HAZARD_PERF_COUNTERS_EN is defined.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        MEM_WAIT   = 2'b01,
        LOAD_STALL = 2'b10
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at 0xFFFF instead of wrapping.
module sat_counter16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [15:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/hazard_flush_controller.sv
// Pipeline hazard/flush controller: stalls, redirects and deferred redirects across data-memory waits.
// Define HAZARD_PERF_COUNTERS_EN to add the FLUSH_COUNT / STALL_COUNT performance outputs.
module hazard_flush_controller
    import hazard_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        PC_MUX_CONTROL,
    input  logic [31:0] BRANCH_OR_JUMP_ADDR,
    input  logic        LOAD_USE_HAZARD,
    input  logic        IMEM_BUSY,
    input  logic        DMEM_BUSY,
    output logic        PC_SEL,
    output logic [31:0] PC_TARGET,
    output logic        PC_WRITE_EN,
    output logic        IF_ID_WRITE_EN,
    output logic        ID_EX_WRITE_EN,
    output logic        EX_MEM_WRITE_EN,
    output logic        IF_ID_FLUSH,
    output logic        ID_EX_FLUSH
`ifdef HAZARD_PERF_COUNTERS_EN
    ,
    output logic [15:0] FLUSH_COUNT,
    output logic [15:0] STALL_COUNT
`endif
);

    state_t      state;
    state_t      state_nxt;
    logic        pending;
    logic [31:0] pending_target;
    logic        capture;
    logic        clear_pending;
    logic        if_id_hold;
    logic        id_ex_hold;

    // Outputs are decoded combinationally so a redirect or stall acts in the same cycle it is seen.
    always_comb begin
        state_nxt       = RUN;
        capture         = 1'b0;
        clear_pending   = 1'b0;
        PC_SEL          = 1'b0;
        PC_TARGET       = BRANCH_OR_JUMP_ADDR;
        PC_WRITE_EN     = 1'b1;
        if_id_hold      = 1'b0;
        id_ex_hold      = 1'b0;
        EX_MEM_WRITE_EN = 1'b1;
        IF_ID_FLUSH     = 1'b0;
        ID_EX_FLUSH     = 1'b0;

        if (DMEM_BUSY) begin
            PC_WRITE_EN     = 1'b0;
            if_id_hold      = 1'b1;
            id_ex_hold      = 1'b1;
            EX_MEM_WRITE_EN = 1'b0;
            state_nxt       = MEM_WAIT;
            capture         = PC_MUX_CONTROL && !pending;
        end else if ((state == MEM_WAIT) && pending) begin
            PC_SEL        = 1'b1;
            PC_TARGET     = pending_target;
            IF_ID_FLUSH   = 1'b1;
            ID_EX_FLUSH   = 1'b1;
            clear_pending = 1'b1;
        end else if (PC_MUX_CONTROL) begin
            PC_SEL      = 1'b1;
            IF_ID_FLUSH = 1'b1;
            ID_EX_FLUSH = 1'b1;
        end else if (LOAD_USE_HAZARD && (state != LOAD_STALL)) begin
            PC_WRITE_EN = 1'b0;
            if_id_hold  = 1'b1;
            ID_EX_FLUSH = 1'b1;
            state_nxt   = LOAD_STALL;
        end else if (IMEM_BUSY) begin
            PC_WRITE_EN = 1'b0;
            if_id_hold  = 1'b1;
        end

        // A register being flushed must be written, or the NOP never lands.
        IF_ID_WRITE_EN = !if_id_hold || IF_ID_FLUSH;
        ID_EX_WRITE_EN = !id_ex_hold || ID_EX_FLUSH;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state          <= RUN;
            pending        <= 1'b0;
            pending_target <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                pending        <= 1'b1;
                pending_target <= BRANCH_OR_JUMP_ADDR;
            end else if (clear_pending) begin
                pending <= 1'b0;
            end
        end
    end

`ifdef HAZARD_PERF_COUNTERS_EN
    sat_counter16 u_flush_count (
        .clk   (CLK),
        .rst_n (RESET_N),
        .inc   (PC_SEL),
        .count (FLUSH_COUNT)
    );

    sat_counter16 u_stall_count (
        .clk   (CLK),
        .rst_n (RESET_N),
        .inc   (!PC_WRITE_EN),
        .count (STALL_COUNT)
    );
`endif

endmodule

// File: tb/tb_hazard_flush_controller.sv
// Scoreboard bench for hazard_flush_controller: directed scenarios plus randomized traffic vs. a reference model.
// Counter outputs are checked only when HAZARD_PERF_COUNTERS_EN is defined.
`timescale 1ns/1ps
module tb_hazard_flush_controller;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        PC_MUX_CONTROL = 1'b0;
    logic [31:0] BRANCH_OR_JUMP_ADDR = '0;
    logic        LOAD_USE_HAZARD = 1'b0;
    logic        IMEM_BUSY = 1'b0;
    logic        DMEM_BUSY = 1'b0;
    logic        PC_SEL;
    logic [31:0] PC_TARGET;
    logic        PC_WRITE_EN;
    logic        IF_ID_WRITE_EN;
    logic        ID_EX_WRITE_EN;
    logic        EX_MEM_WRITE_EN;
    logic        IF_ID_FLUSH;
    logic        ID_EX_FLUSH;
    logic [15:0] flush_count_obs;
    logic [15:0] stall_count_obs;

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [15:0] FLUSH_COUNT;
    logic [15:0] STALL_COUNT;
    assign flush_count_obs = FLUSH_COUNT;
    assign stall_count_obs = STALL_COUNT;
`else
    assign flush_count_obs = '0;
    assign stall_count_obs = '0;
`endif

    hazard_flush_controller dut (
        .CLK                 (CLK),
        .RESET_N             (RESET_N),
        .PC_MUX_CONTROL      (PC_MUX_CONTROL),
        .BRANCH_OR_JUMP_ADDR (BRANCH_OR_JUMP_ADDR),
        .LOAD_USE_HAZARD     (LOAD_USE_HAZARD),
        .IMEM_BUSY           (IMEM_BUSY),
        .DMEM_BUSY           (DMEM_BUSY),
        .PC_SEL              (PC_SEL),
        .PC_TARGET           (PC_TARGET),
        .PC_WRITE_EN         (PC_WRITE_EN),
        .IF_ID_WRITE_EN      (IF_ID_WRITE_EN),
        .ID_EX_WRITE_EN      (ID_EX_WRITE_EN),
        .EX_MEM_WRITE_EN     (EX_MEM_WRITE_EN),
        .IF_ID_FLUSH         (IF_ID_FLUSH),
        .ID_EX_FLUSH         (ID_EX_FLUSH)
`ifdef HAZARD_PERF_COUNTERS_EN
        ,
        .FLUSH_COUNT         (FLUSH_COUNT),
        .STALL_COUNT         (STALL_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        pc_sel;
        logic [31:0] pc_target;
        logic        pc_we;
        logic        if_id_we;
        logic        id_ex_we;
        logic        ex_mem_we;
        logic        if_id_fl;
        logic        id_ex_fl;
        logic [15:0] flush_cnt;
        logic [15:0] stall_cnt;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    passes = 0;

    // Reference model: a deferred redirect waiting on data memory, and whether the
    // previous cycle already charged a load-use bubble.
    bit          m_pend;
    logic [31:0] m_pend_addr;
    bit          m_bubble_done;
    int          m_flushes;
    int          m_stalls;

    task automatic model_step(input bit rst, input bit pcmux, input logic [31:0] addr,
                              input bit lu, input bit imem, input bit dmem, output obs_t e);
        bit          n_pend;
        logic [31:0] n_pend_addr;
        bit          n_bubble;
        if (rst) begin
            m_pend        = 1'b0;
            m_pend_addr   = '0;
            m_bubble_done = 1'b0;
            m_flushes     = 0;
            m_stalls      = 0;
        end
        n_pend      = m_pend;
        n_pend_addr = m_pend_addr;
        n_bubble    = 1'b0;
        e = '{pc_sel: 1'b0, pc_target: addr, pc_we: 1'b1, if_id_we: 1'b1, id_ex_we: 1'b1,
              ex_mem_we: 1'b1, if_id_fl: 1'b0, id_ex_fl: 1'b0, flush_cnt: '0, stall_cnt: '0};
`ifdef HAZARD_PERF_COUNTERS_EN
        e.flush_cnt = 16'(m_flushes);
        e.stall_cnt = 16'(m_stalls);
`endif
        if (dmem) begin
            e.pc_we = 0; e.if_id_we = 0; e.id_ex_we = 0; e.ex_mem_we = 0;
            if (pcmux && !m_pend) begin
                n_pend      = 1'b1;
                n_pend_addr = addr;
            end
        end else if (m_pend) begin
            e.pc_sel = 1; e.pc_target = m_pend_addr; e.if_id_fl = 1; e.id_ex_fl = 1;
            n_pend = 1'b0;
        end else if (pcmux) begin
            e.pc_sel = 1; e.if_id_fl = 1; e.id_ex_fl = 1;
        end else if (lu && !m_bubble_done) begin
            e.pc_we = 0; e.if_id_we = 0; e.id_ex_fl = 1;
            n_bubble = 1'b1;
        end else if (imem) begin
            e.pc_we = 0; e.if_id_we = 0;
        end
        if (!rst) begin
            m_pend        = n_pend;
            m_pend_addr   = n_pend_addr;
            m_bubble_done = n_bubble;
            if (e.pc_sel && m_flushes < 65535) m_flushes++;
            if (!e.pc_we && m_stalls < 65535) m_stalls++;
        end
    endtask

    task automatic cycle(input bit rst, input bit pcmux, input logic [31:0] addr,
                         input bit lu, input bit imem, input bit dmem, input string name);
        obs_t e;
        @(posedge CLK);
        #1;
        RESET_N             = !rst;
        PC_MUX_CONTROL      = pcmux;
        BRANCH_OR_JUMP_ADDR = addr;
        LOAD_USE_HAZARD     = lu;
        IMEM_BUSY           = imem;
        DMEM_BUSY           = dmem;
        model_step(rst, pcmux, addr, lu, imem, dmem, e);
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    initial begin : monitor
        obs_t  act;
        obs_t  e;
        string nm;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                act = '{pc_sel: PC_SEL, pc_target: PC_TARGET, pc_we: PC_WRITE_EN,
                        if_id_we: IF_ID_WRITE_EN, id_ex_we: ID_EX_WRITE_EN,
                        ex_mem_we: EX_MEM_WRITE_EN, if_id_fl: IF_ID_FLUSH, id_ex_fl: ID_EX_FLUSH,
                        flush_cnt: flush_count_obs, stall_cnt: stall_count_obs};
                checks++;
                if (act === e) passes++;
                else $display("FAIL %s: actual=%h expected=%h", nm, act, e);
            end
        end
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, pending=%0d", exp_q.size());
        $display("%0d/%0d checks passed", passes, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        bit          r_rst;
        bit          r_pcmux;
        bit          r_lu;
        bit          r_imem;
        bit          r_dmem;
        logic [31:0] r_addr;

        cycle(1, 0, 32'h0, 0, 0, 0, "reset_state");
        cycle(0, 0, 32'hDEAD_BEEF, 0, 0, 0, "run_defaults");

        cycle(0, 1, 32'h0000_0040, 0, 0, 0, "redirect_0x40");
        cycle(0, 0, 32'h0, 1, 0, 0, "lu_after_redirect");
        cycle(0, 0, 32'h0, 1, 0, 0, "lu_second_cycle_ignored");
        cycle(0, 0, 32'h0, 0, 0, 0, "defaults_after_bubble");

        cycle(0, 1, 32'h0000_0080, 0, 0, 1, "dmem_c1_redirect_0x80");
        cycle(0, 1, 32'h0000_0999, 0, 0, 1, "dmem_c2_redirect_ignored");
        cycle(0, 0, 32'h0, 0, 1, 1, "dmem_c3");
        cycle(0, 0, 32'h0000_1234, 1, 1, 0, "dmem_release_pending_0x80");
        cycle(0, 0, 32'h0, 0, 0, 0, "after_pending_redirect");

        cycle(0, 1, 32'h0000_0200, 1, 0, 0, "redirect_beats_lu");
        cycle(0, 0, 32'h0, 1, 0, 0, "lu_still_stalls");
        cycle(0, 0, 32'h0, 0, 1, 0, "imem_only");
        cycle(0, 0, 32'h0, 1, 1, 0, "lu_over_imem");
        cycle(0, 0, 32'h0, 0, 1, 0, "imem_in_load_stall");

        cycle(0, 1, 32'h0000_0100, 0, 0, 1, "mw_capture_0x100");
        cycle(0, 0, 32'h0, 0, 0, 1, "mw_hold");
        cycle(1, 0, 32'h0, 0, 0, 0, "reset_mid_mem_wait");
        cycle(0, 0, 32'h0, 0, 0, 0, "pending_discarded");
        cycle(0, 0, 32'h0, 0, 0, 1, "dmem_no_pending");
        cycle(0, 1, 32'h0000_0300, 0, 0, 0, "release_live_redirect");

        for (int i = 0; i < 3000; i++) begin
            r_rst   = ($urandom_range(255) == 0);
            r_pcmux = ($urandom_range(3) == 0);
            r_lu    = ($urandom_range(2) == 0);
            r_imem  = ($urandom_range(3) == 0);
            r_dmem  = ($urandom_range(4) == 0);
            r_addr  = $urandom;
            cycle(r_rst, r_pcmux, r_addr, r_lu, r_imem, r_dmem, "random");
        end

`ifdef HAZARD_PERF_COUNTERS_EN
        cycle(1, 0, 32'h0, 0, 0, 0, "reset_before_saturation");
        for (int i = 0; i < 70000; i++) begin
            cycle(0, 0, 32'h0, 0, 1, 0, "imem_saturation");
        end
        cycle(0, 0, 32'h0, 0, 0, 0, "stall_count_saturated");
`endif

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLK);
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: actual=%0d outstanding required=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
